// File: rtl/cpu_async_pkg.sv
// Shared definitions for the cpu_async producer block.
//   state_t         : handshake FSM states (IDLE, REQ, RELEASE)
//   DEF_*           : default parameter values used by the interface and top
package cpu_async_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_GAP_CYCLES  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/cpu_async_if.sv
// Handshake bundle between the cpu_async producer and an asynchronous consumer.
//   ack  : acknowledge from consumer (no timing relation to clk)
//   send : request, high while a transfer is outstanding
//   data : payload word, stable while send is high
//   busy : producer is not idle
//   err  : sticky protocol-violation flag (stale ack at gap expiry)
// master modport is the producer side, slave modport the consumer/observer side.
interface cpu_async_if
    import cpu_async_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              ack;
    logic              send;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              err;

    modport master (
        input  ack,
        output send,
        output data,
        output busy,
        output err
    );

    modport slave (
        output ack,
        input  send,
        input  data,
        input  busy,
        input  err
    );

endinterface

// File: rtl/cpu_async_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   d_i  : asynchronous input
//   q_o  : synchronized output, STAGES clk edges behind d_i
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_async.sv
// Producer side of a 4-phase request/acknowledge handshake.
// Raises send with a data word, waits for ack to rise then fall, advances the
// data word and restarts after GAP_CYCLES idle cycles.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cpu_async_if master modport (ack in; send, data, busy, err out)
module cpu_async
    import cpu_async_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    cpu_async_if.master  bus
);

    localparam int unsigned     CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              send_q,  send_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              err_q,   err_d;
    logic              ack_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.ack),
        .q_o (ack_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            send_q  <= send_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        send_d  = send_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                send_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    // Gap expired: only start once the consumer has dropped ack;
                    // a still-high ack is a leftover and gets flagged.
                    if (!ack_s) begin
                        state_d = REQ;
                        send_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                send_d = 1'b1;
                if (ack_s) begin
                    state_d = RELEASE;
                    send_d  = 1'b0;
                end
            end
            RELEASE: begin
                send_d = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                    data_d  = data_q + DATA_W'(1);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                send_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.send = send_q;
    assign bus.data = data_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_async.sv
// Self-checking bench for cpu_async: a consumer model drives ack with random
// delays, expected request words are queued per transfer and a negedge monitor
// pops and compares them whenever a new request appears.
module tb_cpu_async;
    import cpu_async_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned GAP = 4;
    localparam int unsigned SS  = 2;

    logic clk = 1'b0;
    logic rst;

    cpu_async_if #(.DATA_W(DW)) bus ();

    cpu_async #(
        .DATA_W      (DW),
        .GAP_CYCLES  (GAP),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   model_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return bus.send;
            1:       return bus.busy;
            default: return bus.err;
        endcase
    endfunction

    // Counts rising edges until the selected output equals val; maxe+1 on timeout.
    task automatic edges_until(input int sel, input logic val, input int maxe, output int n);
        n = maxe + 1;
        for (int i = 1; i <= maxe; i++) begin
            @(posedge clk);
            #1;
            if (pick(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Scoreboard monitor: every new request must carry the next queued word.
    logic          prev_send = 1'b0;
    logic [DW-1:0] held;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst) begin
            if (bus.send === 1'b1 && !prev_send) begin
                check("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("req_data", bus.data, e);
                end
                held = bus.data;
            end else if (bus.send === 1'b1 && prev_send) begin
                check("data_stable", bus.data, held);
            end
            if (bus.send === 1'b1) check("busy_with_send", bus.busy, 1);
        end
        prev_send = rst ? 1'b0 : (bus.send === 1'b1);
    end

    // One full transfer seen from the consumer side.
    task automatic handshake(input bit pushed);
        int n;
        if (!pushed) exp_q.push_back(DW'(model_data));
        if (bus.send !== 1'b1) begin
            edges_until(0, 1'b1, GAP + SS + 6, n);
            check("req_seen", bus.send, 1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        bus.ack = 1'b1;
        edges_until(0, 1'b0, 10, n);
        check("ack_to_send_fall", n, SS + 1);
        check("busy_in_release", bus.busy, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.ack = 1'b0;
        edges_until(1, 1'b0, 10, n);
        check("release_to_idle", n, SS + 1);
        model_data = (model_data + 1) % (1 << DW);
        check("data_advance", bus.data, model_data);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        bus.ack    = 1'b0;
        model_data = 0;

        // Reset hold with ack toggling.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) bus.ack = 1'b1;
            #1;
            check("reset_hold", {bus.send, bus.busy, bus.err, bus.data}, 0);
            if (i == 9) bus.ack = 1'b0;
        end

        // Basic handshake with exact edge counts.
        exp_q.push_back(8'h00);
        @(negedge clk);
        rst = 1'b0;
        edges_until(0, 1'b1, 10, n);
        check("first_req_edges", n, GAP);
        check("busy_in_req", bus.busy, 1);
        @(negedge clk);
        bus.ack = 1'b1;
        edges_until(0, 1'b0, 10, n);
        check("ack_latency", n, SS + 1);
        @(negedge clk);
        bus.ack = 1'b0;
        edges_until(1, 1'b0, 10, n);
        check("release_latency", n, SS + 1);
        check("data_after_first", bus.data, 1);
        model_data = 1;
        exp_q.push_back(8'h01);
        edges_until(0, 1'b1, 10, n);
        check("gap_edges", n, GAP);
        handshake(1);

        // Stale ack held across reset release.
        @(negedge clk);
        rst     = 1'b1;
        bus.ack = 1'b1;
        exp_q.delete();
        model_data = 0;
        @(negedge clk);
        rst = 1'b0;
        edges_until(2, 1'b1, 20, n);
        check("stale_err_edge", n, GAP);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            check("stale_no_send", bus.send, 0);
        end
        exp_q.push_back(8'h00);
        @(negedge clk);
        bus.ack = 1'b0;
        edges_until(0, 1'b1, 10, n);
        check("stale_release_edges", n, SS + 1);
        check("err_sticky_req", bus.err, 1);
        handshake(1);
        check("err_sticky_done", bus.err, 1);

        // Wrap-around: 257 transfers from reset, last one carries 0x00 again.
        @(negedge clk);
        rst     = 1'b1;
        bus.ack = 1'b0;
        exp_q.delete();
        model_data = 0;
        @(negedge clk);
        check("err_cleared_by_reset", bus.err, 0);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) handshake(0);

        // Reset in the middle of a request carrying 0x05.
        while (model_data != 5) handshake(0);
        exp_q.push_back(8'h05);
        edges_until(0, 1'b1, 12, n);
        check("mid_req_up", bus.send, 1);
        @(negedge clk);
        check("mid_req_data", bus.data, 8'h05);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_send", bus.send, 0);
        check("async_rst_data", bus.data, 0);
        check("async_rst_busy", bus.busy, 0);
        exp_q.delete();
        model_data = 0;
        bus.ack    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        handshake(0);

        // One-cycle ack glitch while a request is outstanding.
        exp_q.push_back(DW'(model_data));
        edges_until(0, 1'b1, 12, n);
        check("glitch_req_up", bus.send, 1);
        @(posedge clk);
        #3 bus.ack = 1'b1;
        @(posedge clk);
        #3 bus.ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("glitch_no_x", $isunknown({bus.send, bus.busy, bus.err, bus.data}), 0);
        end
        if (bus.send === 1'b1) begin
            handshake(1);
        end else begin
            edges_until(1, 1'b0, 10, n);
            check("glitch_idle", bus.busy, 0);
            model_data = (model_data + 1) % (1 << DW);
            check("glitch_data_advance", bus.data, model_data);
        end
        handshake(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_async.md
Name: cpu_async

Overview:
- Producer ("CPU") side of a 4-phase asynchronous request/acknowledge handshake.
- Repeatedly issues a request on `send`, carrying a data word on `data`.
- Waits for an externally generated, clock-asynchronous `ack` to rise and then fall, advances the data word, and starts the next transfer after a programmable idle gap.
- Sits at the clock-domain boundary in front of an asynchronous consumer.

Parameters:
- DATA_W, 8, width of the data word driven alongside `send`.
- GAP_CYCLES, 4, idle clock cycles between completion of one handshake and the next `send` assertion (minimum 1).
- SYNC_STAGES, 2, number of flip-flops in the `ack` synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately and holds it while high.
- ack  input  1  acknowledge from the asynchronous consumer; no timing relation to clk.
- send  output  1  request; registered; high while a transfer is outstanding.
- data  output  DATA_W  payload word; registered; stable whenever `send` is high.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky protocol-violation flag; registered.

Behaviour:
- Reset (rst=1, asynchronous): send=0, busy=0, err=0, data=0, synchronizer flops=0, gap counter=0, state=IDLE. While rst stays high, outputs never change regardless of `ack` or clk.
- Synchronizer: `ack` passes through SYNC_STAGES flops to give ack_s. The FSM uses only ack_s; raw `ack` never drives logic directly.
- State IDLE:
  - Gap counter increments each cycle.
  - When counter reaches GAP_CYCLES-1 and ack_s=0: go to REQ, set send=1 on that edge, clear counter.
  - If the counter is expired but ack_s=1 (stale ack): remain in IDLE, hold counter, set err=1. Do not assert send until ack_s=0.
- State REQ:
  - send=1, data held constant.
  - When ack_s=1: go to RELEASE and set send=0 on the same edge.
- State RELEASE:
  - send=0.
  - When ack_s=0: increment data by 1 (modulo 2^DATA_W, wraps 0xFF->0x00 at DATA_W=8), go to IDLE, clear gap counter.
- First request after reset release: send rises on the GAP_CYCLES-th rising clk edge after rst deasserts (4th edge at defaults).
- Latency: ack rising edge to send falling edge is SYNC_STAGES+1 rising clk edges (3 at defaults), assuming ack meets setup at the first synchronizer flop.
- `ack` pulses shorter than SYNC_STAGES cycles may be missed. The consumer must hold ack until it sees send fall.
- `err` clears only on reset.
- rst asserted mid-transfer: send drops immediately (asynchronously), data returns to 0, and the FSM restarts at IDLE after release.
- State encoding: IDLE, REQ, RELEASE; no other reachable states. Any illegal encoding recovers to IDLE with send=0.

Decomposition:
- Shared package `cpu_async_pkg`: state enum type (IDLE, REQ, RELEASE), default parameter constants.
- One sub-module is natural: `sync_ff` (parameterized SYNC_STAGES multi-flop synchronizer, async reset to 0) used for `ack`.
- FSM, gap counter and data register live in the top module.

Test Plan:
- Reset hold: rst=1 for 100 ns (10 clocks, 10 ns period), ack toggled 0->1->0 at 50 ns spacing -> send=0, data=0, busy=0, err=0 throughout.
- Basic handshake: release rst, ack=0 -> send=1, data=0x00 on 4th clk edge. Raise ack -> send=0 exactly 3 edges later. Drop ack -> data=0x01, busy=0 within 3 edges, next send after a further 4 cycles.
- Stale ack: release rst with ack=1 held for 20 cycles -> send stays 0, err=1 at gap expiry. Drop ack -> send=1 within SYNC_STAGES+1 edges, err remains 1.
- Wrap-around: complete 256 handshakes -> data sequence 0x00..0xFF, then 0x00 on the 257th request.
- Reset mid-operation: assert rst while send=1, data=0x05 -> send=0 and data=0 immediately without waiting for a clk edge. After release, a normal first request occurs with data=0x00.
- Short ack glitch: 1-cycle ack pulse mid-cycle while in REQ -> send either stays 1 or falls cleanly; no X on outputs, and the next full-length ack completes the transfer.
